// File: rtl/cpu_debug_jtag_scan_host.sv
// rtl/cpu_debug_jtag_scan_host.sv - virtual-JTAG scan sequencer driving the CPU debug slave
module cpu_debug_jtag_scan_host #(
    parameter int DR_W     = 38,
    parameter int IR_W     = 2,
    parameter int TCK_HALF = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [IR_W-1:0] cmd_ir,
    input  logic [DR_W-1:0] cmd_dr,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [DR_W-1:0] rsp_dr,
    output logic [IR_W-1:0] rsp_ir_out,
    output logic            busy,
    output logic            tck,
    output logic            tdi,
    input  logic            tdo,
    output logic [IR_W-1:0] ir_in,
    input  logic [IR_W-1:0] ir_out,
    output logic            vs_uir,
    output logic            vs_cdr,
    output logic            vs_sdr,
    output logic            vs_e1dr,
    output logic            jtag_state_rti
);
    localparam int CW = (TCK_HALF > 1) ? $clog2(TCK_HALF) : 1;
    localparam int BW = (DR_W > 1) ? $clog2(DR_W) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_UIR, S_CDR, S_SDR, S_E1DR, S_RTI, S_RESP
    } state_t;

    state_t          state;
    logic            launch;
    logic            hi;
    logic [CW-1:0]   hcnt;
    logic [BW-1:0]   bcnt;
    logic [IR_W-1:0] ir_q;
    logic [DR_W-1:0] sr;

    wire phase_end = (hcnt == CW'(TCK_HALF - 1));

    assign rsp_dr = sr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            launch         <= 1'b0;
            hi             <= 1'b0;
            hcnt           <= '0;
            bcnt           <= '0;
            ir_q           <= '0;
            sr             <= '0;
            cmd_ready      <= 1'b1;
            rsp_valid      <= 1'b0;
            rsp_ir_out     <= '0;
            busy           <= 1'b0;
            tck            <= 1'b0;
            tdi            <= 1'b0;
            ir_in          <= '0;
            vs_uir         <= 1'b0;
            vs_cdr         <= 1'b0;
            vs_sdr         <= 1'b0;
            vs_e1dr        <= 1'b0;
            jtag_state_rti <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        ir_q           <= cmd_ir;
                        sr             <= cmd_dr;
                        state          <= S_UIR;
                        launch         <= 1'b1;
                        cmd_ready      <= 1'b0;
                        busy           <= 1'b1;
                        jtag_state_rti <= 1'b0;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid      <= 1'b0;
                        state          <= S_IDLE;
                        cmd_ready      <= 1'b1;
                        busy           <= 1'b0;
                        jtag_state_rti <= 1'b1;
                    end
                end
                default: begin
                    // One setup clk after acceptance, then the first UIR low phase begins.
                    if (launch) begin
                        launch <= 1'b0;
                        hi     <= 1'b0;
                        hcnt   <= '0;
                        vs_uir <= 1'b1;
                        ir_in  <= ir_q;
                    end else if (!phase_end) begin
                        hcnt <= hcnt + CW'(1);
                    end else begin
                        hcnt <= '0;
                        hi   <= ~hi;
                        if (!hi) begin
                            tck <= 1'b1;
                            if (state == S_UIR) rsp_ir_out <= ir_out;
                            if (state == S_SDR) sr <= {tdo, sr[DR_W-1:1]};
                        end else begin
                            // End of high phase: first clk of the next low phase drives new state.
                            tck <= 1'b0;
                            case (state)
                                S_UIR: begin
                                    vs_uir <= 1'b0;
                                    vs_cdr <= 1'b1;
                                    bcnt   <= BW'(DR_W - 1);
                                    state  <= S_CDR;
                                end
                                S_CDR: begin
                                    vs_cdr <= 1'b0;
                                    vs_sdr <= 1'b1;
                                    tdi    <= sr[0];
                                    state  <= S_SDR;
                                end
                                S_SDR: begin
                                    if (bcnt == '0) begin
                                        vs_sdr  <= 1'b0;
                                        vs_e1dr <= 1'b1;
                                        tdi     <= 1'b0;
                                        state   <= S_E1DR;
                                    end else begin
                                        bcnt <= bcnt - BW'(1);
                                        tdi  <= sr[0];
                                    end
                                end
                                S_E1DR: begin
                                    vs_e1dr        <= 1'b0;
                                    jtag_state_rti <= 1'b1;
                                    state          <= S_RTI;
                                end
                                default: begin
                                    jtag_state_rti <= 1'b0;
                                    rsp_valid      <= 1'b1;
                                    state          <= S_RESP;
                                end
                            endcase
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_debug_jtag_scan_host.sv
// tb/tb_cpu_debug_jtag_scan_host.sv - self-checking bench for cpu_debug_jtag_scan_host
module tb_cpu_debug_jtag_scan_host;
    localparam int DR_W = 38;
    localparam int IR_W = 2;

    logic            clk = 1'b0;
    logic            reset, sel;
    logic            cmd_valid, rsp_ready;
    logic [IR_W-1:0] cmd_ir, ir_out;
    logic [DR_W-1:0] cmd_dr;
    logic            tdo;
    int              cyc = 0;

    logic            cmd_ready, rsp_valid, busy, tck, tdi;
    logic            vs_uir, vs_cdr, vs_sdr, vs_e1dr, rti;
    logic [DR_W-1:0] rsp_dr;
    logic [IR_W-1:0] rsp_ir_out, ir_in;

    logic            cr_a, rv_a, bz_a, tck_a, tdi_a, u_a, c_a, s_a, e_a, r_a;
    logic [DR_W-1:0] rd_a;
    logic [IR_W-1:0] ri_a, ii_a;
    logic            cr_b, rv_b, bz_b, tck_b, tdi_b, u_b, c_b, s_b, e_b, r_b;
    logic [DR_W-1:0] rd_b;
    logic [IR_W-1:0] ri_b, ii_b;
    logic            reset_a, reset_b;

    assign reset_a = reset | sel;
    assign reset_b = reset | ~sel;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cpu_debug_jtag_scan_host #(.DR_W(DR_W), .IR_W(IR_W), .TCK_HALF(2)) dut (
        .clk(clk), .reset(reset_a), .cmd_valid(cmd_valid), .cmd_ready(cr_a),
        .cmd_ir(cmd_ir), .cmd_dr(cmd_dr), .rsp_valid(rv_a), .rsp_ready(rsp_ready),
        .rsp_dr(rd_a), .rsp_ir_out(ri_a), .busy(bz_a), .tck(tck_a), .tdi(tdi_a),
        .tdo(tdo), .ir_in(ii_a), .ir_out(ir_out), .vs_uir(u_a), .vs_cdr(c_a),
        .vs_sdr(s_a), .vs_e1dr(e_a), .jtag_state_rti(r_a));

    cpu_debug_jtag_scan_host #(.DR_W(DR_W), .IR_W(IR_W), .TCK_HALF(1)) dut1 (
        .clk(clk), .reset(reset_b), .cmd_valid(cmd_valid), .cmd_ready(cr_b),
        .cmd_ir(cmd_ir), .cmd_dr(cmd_dr), .rsp_valid(rv_b), .rsp_ready(rsp_ready),
        .rsp_dr(rd_b), .rsp_ir_out(ri_b), .busy(bz_b), .tck(tck_b), .tdi(tdi_b),
        .tdo(tdo), .ir_in(ii_b), .ir_out(ir_out), .vs_uir(u_b), .vs_cdr(c_b),
        .vs_sdr(s_b), .vs_e1dr(e_b), .jtag_state_rti(r_b));

    assign {cmd_ready, rsp_valid, busy, tck, tdi, vs_uir, vs_cdr, vs_sdr, vs_e1dr, rti,
            rsp_dr, rsp_ir_out, ir_in} = sel ?
           {cr_b, rv_b, bz_b, tck_b, tdi_b, u_b, c_b, s_b, e_b, r_b, rd_b, ri_b, ii_b} :
           {cr_a, rv_a, bz_a, tck_a, tdi_a, u_a, c_a, s_a, e_a, r_a, rd_a, ri_a, ii_a};

    // Loopback slave: a DR_W-bit shift register clocked on rising tck while in SDR.
    logic [DR_W-1:0] slv = '0;
    assign tdo = slv[0];
    always @(posedge tck) if (vs_sdr) slv <= {tdi, slv[DR_W-1:1]};

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic start_cmd(input logic [IR_W-1:0] ir, input logic [DR_W-1:0] dr, output int n);
        int k = 0;
        @(negedge clk);
        while (!cmd_ready && k < 1000) begin @(negedge clk); k++; end
        check("cmd_ready_wait", 64'(k < 1000), 64'd1);
        cmd_valid = 1'b1; cmd_ir = ir; cmd_dr = dr;
        @(negedge clk);
        cmd_valid = 1'b0;
        n = cyc;
    endtask

    task automatic do_scan(input logic [IR_W-1:0] ir, input logic [DR_W-1:0] dr,
                           input logic [IR_W-1:0] iro, input int th, input int hold,
                           input logic [DR_W-1:0] exp_dr);
        int n, k, first, ov, bad;
        int cu, cc, cs, ce, cr;
        logic prev;
        logic [IR_W-1:0] uir_ir;
        ir_out = iro;
        rsp_ready = (hold == 0);
        start_cmd(ir, dr, n);
        check("accept_busy", {62'd0, busy, cmd_ready}, 64'b10);
        k = 0; first = -1; ov = 0; prev = 1'b0; uir_ir = '0;
        cu = 0; cc = 0; cs = 0; ce = 0; cr = 0;
        while (!rsp_valid && k < 2000) begin
            if (tck && !prev) begin
                if (first < 0) first = cyc - n;
                cu += int'(vs_uir); cc += int'(vs_cdr); cs += int'(vs_sdr);
                ce += int'(vs_e1dr); cr += int'(rti);
            end
            if (vs_uir) uir_ir = ir_in;
            if (int'(vs_uir) + int'(vs_cdr) + int'(vs_sdr) + int'(vs_e1dr) + int'(rti) > 1) ov++;
            prev = tck;
            @(negedge clk);
            k++;
        end
        check("rsp_latency", 64'(cyc - n), 64'((DR_W + 4) * 2 * th + 1));
        check("first_tck_rise", 64'(first), 64'(th + 1));
        check("rsp_dr", 64'(rsp_dr), 64'(exp_dr));
        check("rsp_ir_out", 64'(rsp_ir_out), 64'(iro));
        check("ir_in_uir", 64'(uir_ir), 64'(ir));
        check("flag_counts", {24'd0, 8'(cu), 8'(cc), 8'(cs), 8'(ce), 8'(cr)},
              {24'd0, 8'd1, 8'd1, 8'(DR_W), 8'd1, 8'd1});
        check("flag_overlap", 64'(ov), 64'd0);
        if (hold > 0) begin
            bad = 0;
            for (int i = 0; i < hold; i++) begin
                cmd_valid = (i == 20 || i == 21);
                @(negedge clk);
                if (!rsp_valid || rsp_dr !== exp_dr || rsp_ir_out !== iro ||
                    cmd_ready || tck || !busy) bad++;
            end
            cmd_valid = 1'b0;
            check("backpressure_hold", 64'(bad), 64'd0);
            rsp_ready = 1'b1;
        end
        @(negedge clk);
        check("rsp_release", {62'd0, rsp_valid, cmd_ready}, 64'b01);
        check("ir_in_hold", 64'(ir_in), 64'(ir));
    endtask

    typedef struct {
        logic [IR_W-1:0] ir;
        logic [DR_W-1:0] dr;
        logic [IR_W-1:0] iro;
        logic [DR_W-1:0] exp_dr;
    } vec_t;

    vec_t            tbl[8];
    logic [DR_W-1:0] model;
    logic [DR_W-1:0] r;
    int              n, k;

    initial begin
        reset = 1'b1; sel = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b1;
        cmd_ir = '0; cmd_dr = '0; ir_out = '0;
        repeat (3) @(negedge clk);
        check("reset_ctrl", {59'd0, cmd_ready, busy, tck, rsp_valid, rti}, 64'b10001);
        check("reset_flags", {58'd0, vs_uir, vs_cdr, vs_sdr, vs_e1dr, ir_in}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        model = '0;
        tbl[0] = '{2'b10, 38'h2A_5A5A_A5A5, 2'b01, '0};
        tbl[1] = '{2'b10, 38'h2A_5A5A_A5A5, 2'b01, '0};
        tbl[2] = '{2'b01, {DR_W{1'b1}}, 2'b10, '0};
        tbl[3] = '{2'b11, '0, 2'b11, '0};
        for (int i = 4; i < 8; i++)
            tbl[i] = '{2'($urandom), {6'($urandom), 32'($urandom)}, 2'($urandom), '0};
        // Each scan returns what the previous scan left in the slave.
        for (int i = 0; i < 8; i++) begin
            tbl[i].exp_dr = model;
            model = tbl[i].dr;
        end
        for (int i = 0; i < 8; i++)
            do_scan(tbl[i].ir, tbl[i].dr, tbl[i].iro, 2, 0, tbl[i].exp_dr);

        r = {6'($urandom), 32'($urandom)};
        do_scan(2'b01, r, 2'b10, 2, 50, model);
        model = r;

        r = {6'($urandom), 32'($urandom)};
        start_cmd(2'b11, r, n);
        k = 0;
        begin
            int rises = 0;
            logic prev = 1'b0;
            while (rises < 10 && k < 2000) begin
                if (tck && !prev && vs_sdr) rises++;
                prev = tck;
                if (rises < 10) begin @(negedge clk); k++; end
            end
        end
        check("sdr_10_bits_reached", 64'(k < 2000), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_reset", {59'd0, tck, vs_sdr, busy, cmd_ready, rsp_valid}, 64'b00010);
        model = {r[9:0], model[DR_W-1:10]};
        r = {6'($urandom), 32'($urandom)};
        do_scan(2'b10, r, 2'b01, 2, 0, model);
        model = r;

        sel = 1'b1;
        repeat (2) @(negedge clk);
        do_scan(2'b10, 38'h2A_5A5A_A5A5, 2'b01, 1, 0, model);
        do_scan(2'b10, 38'h2A_5A5A_A5A5, 2'b01, 1, 0, 38'h2A_5A5A_A5A5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
